// File: rtl/square_seq.sv
// Sequential shift-add squarer: sq_o = s_i * s_i after 2W+1 cycles, St/Done level handshake.
// Define SQUARE_DEBUG_EN to expose the FSM code (state_o) and captured operand (dataCopy_o).
module square_seq #(
  parameter int W = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           st_i,
  input  logic [W-1:0]   s_i,
  output logic           done_o,
  output logic [2*W-1:0] sq_o
`ifdef SQUARE_DEBUG_EN
  ,
  output logic [2:0]     state_o,
  output logic [W-1:0]   dataCopy_o
`endif
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         stateQ;
  logic [2*W-1:0] opAQ;
  logic [W-1:0]   opBQ;
  logic [2*W-1:0] accQ;
  logic [CW-1:0]  cntQ;
  logic [W-1:0]   capQ;
  logic [2*W-1:0] sqQ;
  logic           doneQ;
  logic [CW-1:0]  cntD;

  assign cntD = cntQ - CW'(1);

  // One ADD/SHIFT pair per multiplier bit; the result is latched into sqQ only on DONE entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateQ <= IDLE;
      opAQ   <= '0;
      opBQ   <= '0;
      accQ   <= '0;
      cntQ   <= '0;
      capQ   <= '0;
      sqQ    <= '0;
      doneQ  <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (st_i) begin
            capQ   <= s_i;
            stateQ <= LOAD;
          end
        end
        LOAD: begin
          opAQ   <= {{W{1'b0}}, capQ};
          opBQ   <= capQ;
          accQ   <= '0;
          cntQ   <= CW'(W);
          stateQ <= ADD;
        end
        ADD: begin
          if (opBQ[0]) accQ <= accQ + opAQ;
          stateQ <= SHIFT;
        end
        SHIFT: begin
          opAQ <= opAQ << 1;
          opBQ <= opBQ >> 1;
          cntQ <= cntD;
          if (cntD == '0) begin
            sqQ    <= accQ;
            doneQ  <= 1'b1;
            stateQ <= DONE;
          end else begin
            stateQ <= ADD;
          end
        end
        DONE: begin
          if (!st_i) begin
            doneQ  <= 1'b0;
            stateQ <= IDLE;
          end
        end
        default: begin
          doneQ  <= 1'b0;
          stateQ <= IDLE;
        end
      endcase
    end
  end

  assign done_o = doneQ;
  assign sq_o   = sqQ;

`ifdef SQUARE_DEBUG_EN
  assign state_o    = stateQ;
  assign dataCopy_o = capQ;
`endif

endmodule
